// File: rtl/mem_access.sv
// mem_access: multi-cycle load/store unit between execute and the data RAM.
// Drives a synchronous RAM port and returns extended load data.
module mem_access #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       rdata_out,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;

    logic        legal;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [31:0] shifted;
    logic [31:0] ext;

    // High address bits alias away by design.
    logic unused_hi;
    assign unused_hi = &{1'b0, addr[31:ADDR_W+2]};

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = ~we;
            3'b101:  legal = ~we & ~addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        be_n = 4'b1111;
        wd_n = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_n = 4'b0001 << addr[1:0];
                wd_n = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_n = addr[1] ? 4'b1100 : 4'b0011;
                wd_n = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'b0, shifted[7:0]};
            3'b101:  ext = {16'b0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_out <= '0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            we_q      <= 1'b0;
        end else begin
            done   <= 1'b0;
            fault  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                // DONE accepts a new request so back-to-back ops lose no cycle.
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (req && legal) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= we;
                        mem_be    <= be_n;
                        mem_wdata <= wd_n;
                        mem_addr  <= addr[ADDR_W+1:2];
                        off_q     <= addr[1:0];
                        f3_q      <= funct3;
                        we_q      <= we;
                    end else if (req) begin
                        fault <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rdata_out <= ext;
                    state     <= DONE;
                    done      <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for mem_access.
// Byte-level reference memory predicts RAM traffic and load results.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, fault, mem_en, mem_we;
    logic [31:0] rdata_out, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;

    mem_access #(.ADDR_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .fault(fault),
        .rdata_out(rdata_out), .mem_en(mem_en), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          flt;
        bit          load;
        logic [31:0] rd;
        int          cyc;
    } done_t;

    typedef struct {
        logic [13:0] wa;
        bit          w;
        logic [3:0]  be;
        logic [31:0] wd;
    } acc_t;

    done_t done_q[$];
    acc_t  acc_q[$];

    logic [31:0] ram [0:16383];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] last_ld = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic chk(bit ok, string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed memory, size = 1 << funct3[1:0].
    task automatic push_expect(bit w, logic [2:0] f, logic [31:0] a,
                               logic [31:0] d, int c);
        int          sz;
        bit          ok;
        int          ba;
        logic [31:0] v;
        logic [31:0] mask;
        acc_t        ae;
        done_t       de;
        ok = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz = 1 << f[1:0];
        ok = ok && ((a & (sz - 1)) == 0);
        ba = int'(a[15:0]);
        if (!ok) begin
            de = '{flt: 1'b1, load: 1'b0, rd: last_ld, cyc: c + 1};
            done_q.push_back(de);
            return;
        end
        ae.wa = a[15:2];
        ae.w = w;
        ae.be = 4'((32'd1 << sz) - 1) << a[1:0];
        for (int j = 0; j < 4; j++) ae.wd[8*j +: 8] = d[8*(j % sz) +: 8];
        if (!w) ae.be = (sz == 4) ? 4'hF : ae.be;
        acc_q.push_back(ae);
        if (w) begin
            for (int i = 0; i < sz; i++) ref_mem[ba + i] = d[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[ba + i];
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
            if (!f[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
            last_ld = v;
        end
        de = '{flt: 1'b0, load: !w, rd: last_ld, cyc: c + (w ? 2 : 3)};
        done_q.push_back(de);
    endtask

    initial begin : monitor
        acc_t  a;
        done_t d;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (mem_en) begin
                    chk(acc_q.size() != 0, "unexpected_access", {18'b0, mem_addr}, 0);
                    if (acc_q.size() != 0) begin
                        a = acc_q.pop_front();
                        chk(mem_addr == a.wa, "mem_addr", {18'b0, mem_addr}, {18'b0, a.wa});
                        chk(mem_we == a.w, "mem_we", {31'b0, mem_we}, {31'b0, a.w});
                        if (a.w) begin
                            chk(mem_be == a.be, "mem_be", {28'b0, mem_be}, {28'b0, a.be});
                            chk(mem_wdata == a.wd, "mem_wdata", mem_wdata, a.wd);
                        end
                        chk(busy, "busy_issue", {31'b0, busy}, 1);
                    end
                end
                if (done) begin
                    chk(done_q.size() != 0, "unexpected_done", 1, 0);
                    if (done_q.size() != 0) begin
                        d = done_q.pop_front();
                        chk(cyc == d.cyc, "done_cycle", cyc, d.cyc);
                        chk(fault == d.flt, "fault", {31'b0, fault}, {31'b0, d.flt});
                        chk(busy == !d.flt, "busy_done", {31'b0, busy}, {31'b0, !d.flt});
                        chk(rdata_out == d.rd, "rdata_out", rdata_out, d.rd);
                    end
                end else if (fault) begin
                    chk(1'b0 != done, "fault_without_done", 1, 0);
                end
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 12 && done_q.size() != 0; i++) @(posedge clk);
        chk(done_q.size() == 0, "completion_timeout", done_q.size(), 0);
        done_q.delete();
    endtask

    task automatic do_op(bit w, logic [2:0] f, logic [31:0] a, logic [31:0] d);
        @(posedge clk);
        #1;
        req = 1'b1;
        we = w;
        funct3 = f;
        addr = a;
        wdata = d;
        push_expect(w, f, a, d, cyc + 1);
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_drain();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          c;
        logic [31:0] v;
        logic [2:0]  f;
        logic [31:0] a;
        for (int i = 0; i < 16384; i++) begin
            v = $urandom;
            ram[i] = v;
            for (int j = 0; j < 4; j++) ref_mem[4*i + j] = v[8*j +: 8];
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk(busy == 0, "rst_busy", {31'b0, busy}, 0);
        chk(done == 0, "rst_done", {31'b0, done}, 0);
        chk(fault == 0, "rst_fault", {31'b0, fault}, 0);
        chk(mem_en == 0, "rst_mem_en", {31'b0, mem_en}, 0);
        chk(mem_we == 0, "rst_mem_we", {31'b0, mem_we}, 0);
        chk(mem_be == 0, "rst_mem_be", {28'b0, mem_be}, 0);
        chk(mem_addr == 0, "rst_mem_addr", {18'b0, mem_addr}, 0);
        chk(mem_wdata == 0, "rst_mem_wdata", mem_wdata, 0);
        chk(rdata_out == 0, "rst_rdata", rdata_out, 0);

        do_op(1, 3'b010, 32'h10, 32'hDEADBEEF);
        do_op(0, 3'b010, 32'h10, 0);
        do_op(1, 3'b000, 32'h13, 32'h80);
        do_op(0, 3'b000, 32'h13, 0);
        do_op(0, 3'b100, 32'h13, 0);
        do_op(1, 3'b001, 32'h22, 32'h8001);
        do_op(0, 3'b001, 32'h22, 0);
        do_op(0, 3'b101, 32'h22, 0);
        do_op(0, 3'b010, 32'h01, 0);
        do_op(1, 3'b001, 32'h03, 32'h1234);
        do_op(0, 3'b011, 32'h10, 0);
        do_op(1, 3'b010, 32'h0001_0040, 32'hA5A5_5A5A);
        do_op(0, 3'b010, 32'h40, 0);

        // req held through the whole load; second op accepted as DONE ends
        @(posedge clk);
        #1;
        req = 1'b1;
        we = 1'b0;
        funct3 = 3'b010;
        addr = 32'h10;
        c = cyc + 1;
        push_expect(0, 3'b010, 32'h10, 0, c);
        @(posedge clk);
        #1;
        addr = 32'h20;
        push_expect(0, 3'b010, 32'h20, 0, c + 3);
        repeat (3) @(posedge clk);
        #1;
        req = 1'b0;
        wait_drain();

        // reset asserted while the load sits in WAIT
        @(posedge clk);
        #1;
        req = 1'b1;
        we = 1'b0;
        funct3 = 3'b010;
        addr = 32'h10;
        push_expect(0, 3'b010, 32'h10, 0, cyc + 1);
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk(mem_en == 0, "rstw_mem_en", {31'b0, mem_en}, 0);
        chk(busy == 0, "rstw_busy", {31'b0, busy}, 0);
        chk(done == 0, "rstw_done", {31'b0, done}, 0);
        chk(rdata_out == 0, "rstw_rdata", rdata_out, 0);
        done_q.delete();
        acc_q.delete();
        last_ld = '0;
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk(rdata_out == 0, "rstw_rdata_held", rdata_out, 0);
        do_op(0, 3'b010, 32'h10, 0);

        for (int n = 0; n < 200; n++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'h0000_00FF;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'd3 >> (2 - f[1:0]));
            if ($urandom_range(0, 3) != 0 && f[1:0] == 2'b11) f[1:0] = 2'b10;
            do_op(1'($urandom_range(0, 1)), f, a, $urandom);
        end

        repeat (4) @(posedge clk);
        chk(acc_q.size() == 0, "leftover_access", acc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
